mux32_rr_arb: RTL and testbench
===============================

# mux32_rr_arb

Round-robin arbiter and sequencer for one shared 32-bit 4:1 datapath mux. It grants one of four requesters and drives the mux select pair from a registered grant. It presents the selected 32-bit word with a valid/ready handshake to a single downstream consumer. Locked multi-beat transfers are supported, and a beat-count limit forces rotation so no requester can starve the others.

## Interface
- HOLD_MAX, 8: maximum consecutive beats one requester may hold the grant under lock; legal range 1..16.
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  4  request per requester i; must stay high until the requester sees ack[i].
- lock  in  4  lock[i] high on an accepted beat asks to keep the grant for another beat.
- din0, din1, din2, din3  in  32 each  requester data words.
- out_ready  in  1  downstream consumer can accept a beat this cycle.
- gnt  out  4  registered one-hot grant; 0000 when idle.
- sel_s0, sel_s1  out  1 each  registered mux select, {sel_s1, sel_s0} = granted index.
- dout  out  32  selected data word, equal to din[{sel_s1, sel_s0}] through the 4:1 mux.
- out_valid  out  1  dout is valid.
- ack  out  4  one-cycle pulse: the beat from requester i was accepted this cycle.

## Operation
- The state machine has two states, IDLE and BUSY. Registered state: gnt, sel pair, last_idx (2 bits), beat_cnt (4 bits).
- Reset values:
  - State is IDLE.
  - gnt = 0000 and sel = 00.
  - last_idx = 3, so requester 0 has first priority after reset.
  - beat_cnt = 0.
- Combinational outputs while rst is high: out_valid = 0 and ack = 0000.
- Round-robin pick: scan indices last_idx+1, last_idx+2, last_idx+3, last_idx+4, all modulo 4. The first index with req high wins. The previous holder has lowest priority.
- IDLE:
  - out_valid = 0.
  - If req is nonzero, the next edge loads gnt, sel and beat_cnt = 0, and the state moves to BUSY.
  - Otherwise the state stays IDLE and sel holds its last value.
- BUSY, with g = granted index:
  - out_valid = req[g].
  - ack[g] = out_valid & out_ready.
  - dout = din[g].
- Beat accepted, lock[g] = 1 and beat_cnt < HOLD_MAX-1:
  - Stay on g and increment beat_cnt.
- Beat accepted, other cases:
  - Release: last_idx = g.
  - Re-pick at the same edge, with g now lowest priority. The pick uses current req, ignoring the requester being released only if its req is low.
  - If a winner exists, load the new gnt and sel, clear beat_cnt and stay BUSY, with no idle bubble.
  - If there is no winner, go to IDLE with gnt = 0000.
- req[g] low in BUSY (withdrawal): release exactly as above at that edge, with no ack.
- out_ready high while out_valid is low has no effect.
- Only the granted index can ever see ack; requests on non-granted lines are ignored until the next pick.
- With HOLD_MAX = 1, lock is ignored and every beat releases.

## Timing
- Grant latency from IDLE: req rises in cycle n, gnt and sel are valid in cycle n+1, and out_valid is high in cycle n+1.
- Handoff: after an accepted release beat in cycle n, the new requester's out_valid is high in cycle n+1. Sustained throughput is one beat per cycle.
- out_valid, ack and dout are combinational from the registered gnt/sel, req and out_ready. There is no path from out_ready to gnt within a cycle.
- sel changes only at edges and only together with gnt, so dout is stable within a cycle.
- Reset mid-transfer: a beat presented while rst is high is not acked. The next edge returns the block to the reset values.
- Maximum wait for a continuously requesting line: 3 × HOLD_MAX beats.

## Test plan
- Reset, then req = 0001 with din0 = 0xDEADBEEF and out_ready = 1.
  - Expected: cycle 1 has gnt = 0001, sel = 00, dout = 0xDEADBEEF, out_valid = 1 and ack = 0001.
  - After the beat, with req dropped: IDLE, gnt = 0000.
- req = 1111 held, lock = 0, out_ready = 1.
  - Expected: grant order 0, 1, 2, 3, 0 on consecutive cycles, with no bubble.
  - sel sequence 00, 01, 10, 11.
- HOLD_MAX = 8, req = 0011, lock = 0001, out_ready = 1.
  - Expected: requester 0 receives exactly 8 consecutive acks, then gnt = 0010 on the next cycle.
- Granted requester 2 with out_ready = 0 for 5 cycles.
  - Expected: out_valid stays 1, ack = 0000, and gnt is unchanged.
  - Raising out_ready then gives an ack[2] pulse of one cycle.
- Granted requester 1 drops req before acceptance.
  - Expected: no ack, and the next edge grants the next requester (for example 3 if req = 1000), or goes to IDLE if req = 0000.
- Assert rst during a locked burst at beat 3.
  - Expected: out_valid = 0 and ack = 0000 in the rst cycle.
  - The next cycle has gnt = 0000 and sel = 00, and with req = 1111 requester 0 wins first.

Source files
------------

// File: rtl/mux32_rr_arb.sv
// Round-robin arbiter that sequences four 32-bit requesters through one shared 4:1 mux.
// The grant and mux select are registered. The valid/ready/ack outputs and dout are combinational from them.
module mux32_rr_arb #(
  parameter int HOLD_MAX = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req,
  input  logic [3:0]  lock,
  input  logic [31:0] din0,
  input  logic [31:0] din1,
  input  logic [31:0] din2,
  input  logic [31:0] din3,
  input  logic        out_ready,
  output logic [3:0]  gnt,
  output logic        sel_s0,
  output logic        sel_s1,
  output logic [31:0] dout,
  output logic        out_valid,
  output logic [3:0]  ack,
  output logic        dbg_busy
);

  // Handshake: a beat transfers when out_valid && out_ready are both high in the same cycle.
  // ack pulses for that one cycle on the granted line only.
  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

  localparam logic [3:0] HOLD_LIM = 4'(HOLD_MAX - 1);

  state_e      state_q, state_d;
  logic [3:0]  gnt_q, gnt_d;
  logic [1:0]  sel_q, sel_d;
  logic [1:0]  last_idx_q, last_idx_d;
  logic [3:0]  beat_cnt_q, beat_cnt_d;

  logic        accept;
  logic        hold;
  logic        release_g;
  logic [2:0]  pick;

  // Returns {found, index}. The scan starts at last+1, so last itself is checked last.
  function automatic logic [2:0] rr_pick(input logic [1:0] last, input logic [3:0] r);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 4; k >= 1; k--) begin
      idx = last + 2'(k);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  always_comb begin
    out_valid = !rst && (state_q == BUSY) && req[sel_q];
    accept    = out_valid && out_ready;
    ack       = accept ? (4'b0001 << sel_q) : 4'b0000;
    case (sel_q)
      2'd0:    dout = din0;
      2'd1:    dout = din1;
      2'd2:    dout = din2;
      default: dout = din3;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    sel_d      = sel_q;
    last_idx_d = last_idx_q;
    beat_cnt_d = beat_cnt_q;
    hold       = 1'b0;
    release_g  = 1'b0;
    pick       = 3'b000;
    case (state_q)
      IDLE: begin
        pick = rr_pick(last_idx_q, req);
        if (pick[2]) begin
          state_d    = BUSY;
          sel_d      = pick[1:0];
          gnt_d      = 4'b0001 << pick[1:0];
          beat_cnt_d = 4'd0;
        end
      end
      default: begin
        hold      = accept && lock[sel_q] && (beat_cnt_q < HOLD_LIM);
        release_g = (accept && !hold) || !req[sel_q];
        if (hold) begin
          beat_cnt_d = beat_cnt_q + 4'd1;
        end else if (release_g) begin
          // The outgoing holder is still eligible, but only at lowest priority.
          last_idx_d = sel_q;
          pick       = rr_pick(sel_q, req);
          beat_cnt_d = 4'd0;
          if (pick[2]) begin
            sel_d = pick[1:0];
            gnt_d = 4'b0001 << pick[1:0];
          end else begin
            state_d = IDLE;
            gnt_d   = 4'b0000;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      gnt_q      <= 4'b0000;
      sel_q      <= 2'b00;
      last_idx_q <= 2'd3;
      beat_cnt_q <= 4'd0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      sel_q      <= sel_d;
      last_idx_q <= last_idx_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign gnt      = gnt_q;
  assign sel_s0   = sel_q[0];
  assign sel_s1   = sel_q[1];
  assign dbg_busy = (state_q == BUSY);

endmodule

// File: tb/tb_mux32_rr_arb.sv
// Directed bench for mux32_rr_arb: a per-cycle vector table, an accepted-beat scoreboard,
// and short hand sequences for HOLD_MAX = 1 and for a bounded grant wait.
module tb_mux32_rr_arb;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] lock;
    logic       rdy;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       vld;
    logic [3:0] ack;
  } vec_t;

  logic        clk;
  logic        rst, out_ready;
  logic [3:0]  req, lock;
  logic [31:0] din0, din1, din2, din3;
  logic [3:0]  gnt, ack;
  logic        sel_s0, sel_s1, out_valid, dbg_busy;
  logic [31:0] dout;

  logic        h_rst, h_ready;
  logic [3:0]  h_req, h_lock, h_gnt, h_ack;
  logic        h_s0, h_s1, h_valid, h_busy;
  logic [31:0] h_dout;

  int          n_checks = 0;
  int          n_fail   = 0;
  vec_t        tbl[64];
  int          n_rows = 0;
  logic [31:0] din_arr[4];
  logic [31:0] exp_q[$];

  mux32_rr_arb #(.HOLD_MAX(8)) dut (
    .clk(clk), .rst(rst), .req(req), .lock(lock),
    .din0(din0), .din1(din1), .din2(din2), .din3(din3),
    .out_ready(out_ready), .gnt(gnt), .sel_s0(sel_s0), .sel_s1(sel_s1),
    .dout(dout), .out_valid(out_valid), .ack(ack), .dbg_busy(dbg_busy)
  );

  mux32_rr_arb #(.HOLD_MAX(1)) dut_h1 (
    .clk(clk), .rst(h_rst), .req(h_req), .lock(h_lock),
    .din0(din0), .din1(din1), .din2(din2), .din3(din3),
    .out_ready(h_ready), .gnt(h_gnt), .sel_s0(h_s0), .sel_s1(h_s1),
    .dout(h_dout), .out_valid(h_valid), .ack(h_ack), .dbg_busy(h_busy)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic [3:0] rq, input logic [3:0] lk, input logic rd,
                     input logic [3:0] g, input logic [1:0] s, input logic v, input logic [3:0] a);
    tbl[n_rows] = '{rst: r, req: rq, lock: lk, rdy: rd, gnt: g, sel: s, vld: v, ack: a};
    n_rows++;
  endtask

  task automatic apply_row(input int i);
    @(negedge clk);
    rst       = tbl[i].rst;
    req       = tbl[i].req;
    lock      = tbl[i].lock;
    out_ready = tbl[i].rdy;
    #1;
    chk("gnt", i, 32'(gnt), 32'(tbl[i].gnt));
    chk("sel", i, 32'({sel_s1, sel_s0}), 32'(tbl[i].sel));
    chk("out_valid", i, 32'(out_valid), 32'(tbl[i].vld));
    chk("ack", i, 32'(ack), 32'(tbl[i].ack));
    chk("dout", i, dout, din_arr[tbl[i].sel]);
    chk("dbg_busy", i, 32'(dbg_busy), 32'(tbl[i].gnt != 4'b0000));
    if (tbl[i].ack != 4'b0000) exp_q.push_back(din_arr[tbl[i].sel]);
    if (ack != 4'b0000) begin
      if (exp_q.size() == 0) chk("sb_unexpected_ack", i, 32'(ack), 32'h0);
      else chk("sb_beat", i, dout, exp_q.pop_front());
    end
  endtask

  initial begin
    bit found;
    din0 = 32'hDEADBEEF; din1 = 32'h1111_1111; din2 = 32'h2222_2222; din3 = 32'h3333_3333;
    din_arr[0] = din0; din_arr[1] = din1; din_arr[2] = din2; din_arr[3] = din3;
    rst = 1'b1; req = 4'h0; lock = 4'h0; out_ready = 1'b0;
    h_rst = 1'b1; h_req = 4'h0; h_lock = 4'h0; h_ready = 1'b0;

    // Single request, then withdrawal to IDLE
    add(1, 4'h0, 4'h0, 0, 4'h0, 2'd0, 0, 4'h0);
    add(0, 4'h1, 4'h0, 1, 4'h0, 2'd0, 0, 4'h0);
    add(0, 4'h1, 4'h0, 1, 4'h1, 2'd0, 1, 4'h1);
    add(0, 4'h0, 4'h0, 1, 4'h1, 2'd0, 0, 4'h0);
    add(0, 4'h0, 4'h0, 1, 4'h0, 2'd0, 0, 4'h0);
    // Full rotation, no bubble
    add(1, 4'hF, 4'h0, 1, 4'h0, 2'd0, 0, 4'h0);
    add(0, 4'hF, 4'h0, 1, 4'h0, 2'd0, 0, 4'h0);
    add(0, 4'hF, 4'h0, 1, 4'h1, 2'd0, 1, 4'h1);
    add(0, 4'hF, 4'h0, 1, 4'h2, 2'd1, 1, 4'h2);
    add(0, 4'hF, 4'h0, 1, 4'h4, 2'd2, 1, 4'h4);
    add(0, 4'hF, 4'h0, 1, 4'h8, 2'd3, 1, 4'h8);
    add(0, 4'hF, 4'h0, 1, 4'h1, 2'd0, 1, 4'h1);
    // Locked burst capped at 8 beats
    add(0, 4'h3, 4'h1, 1, 4'h2, 2'd1, 1, 4'h2);
    for (int k = 0; k < 8; k++) add(0, 4'h3, 4'h1, 1, 4'h1, 2'd0, 1, 4'h1);
    add(0, 4'h3, 4'h0, 1, 4'h2, 2'd1, 1, 4'h2);
    // Requester 2 stalled by out_ready
    add(0, 4'h4, 4'h0, 0, 4'h1, 2'd0, 0, 4'h0);
    for (int k = 0; k < 5; k++) add(0, 4'h4, 4'h0, 0, 4'h4, 2'd2, 1, 4'h0);
    add(0, 4'h4, 4'h0, 1, 4'h4, 2'd2, 1, 4'h4);
    add(0, 4'h2, 4'h0, 0, 4'h4, 2'd2, 0, 4'h0);
    // Requester 1 withdraws before acceptance
    add(0, 4'hA, 4'h0, 0, 4'h2, 2'd1, 1, 4'h0);
    add(0, 4'h8, 4'h0, 1, 4'h2, 2'd1, 0, 4'h0);
    add(0, 4'h8, 4'h0, 1, 4'h8, 2'd3, 1, 4'h8);
    add(0, 4'h2, 4'h0, 0, 4'h8, 2'd3, 0, 4'h0);
    add(0, 4'h0, 4'h0, 1, 4'h2, 2'd1, 0, 4'h0);
    add(0, 4'h0, 4'h0, 0, 4'h0, 2'd1, 0, 4'h0);
    // Reset during a locked burst at beat 3
    add(0, 4'h1, 4'h1, 1, 4'h0, 2'd1, 0, 4'h0);
    add(0, 4'h1, 4'h1, 1, 4'h1, 2'd0, 1, 4'h1);
    add(0, 4'h1, 4'h1, 1, 4'h1, 2'd0, 1, 4'h1);
    add(1, 4'h1, 4'h1, 1, 4'h1, 2'd0, 0, 4'h0);
    add(0, 4'hF, 4'h0, 1, 4'h0, 2'd0, 0, 4'h0);
    add(0, 4'hF, 4'h0, 1, 4'h1, 2'd0, 1, 4'h1);

    repeat (2) @(posedge clk);
    for (int i = 0; i < n_rows; i++) apply_row(i);
    chk("sb_leftover", n_rows, 32'(exp_q.size()), 32'd0);

    // HOLD_MAX = 1: lock is ignored, so the two requesters alternate every beat
    @(negedge clk);
    h_rst = 1'b0; h_req = 4'h3; h_lock = 4'h3; h_ready = 1'b1;
    #1 chk("h1_gnt", 0, 32'(h_gnt), 32'h0);
    @(negedge clk); #1;
    chk("h1_gnt", 1, 32'(h_gnt), 32'h1);
    chk("h1_ack", 1, 32'(h_ack), 32'h1);
    @(negedge clk); #1;
    chk("h1_gnt", 2, 32'(h_gnt), 32'h2);
    chk("h1_ack", 2, 32'(h_ack), 32'h2);
    @(negedge clk); #1;
    chk("h1_gnt", 3, 32'(h_gnt), 32'h1);
    chk("h1_dout", 3, h_dout, din0);

    // Bounded wait: a lone request from IDLE is granted one cycle later
    @(negedge clk);
    rst = 1'b1; req = 4'h0; lock = 4'h0; out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0; req = 4'h4;
    found = 1'b0;
    for (int c = 1; c <= 4 && !found; c++) begin
      @(negedge clk); #1;
      if (gnt == 4'h4) begin
        found = 1'b1;
        chk("grant_latency", c, 32'(c), 32'd1);
        chk("grant_dout", c, dout, din2);
      end
    end
    if (!found) chk("grant_timeout", 4, 32'(gnt), 32'h4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
